// File: rtl/sd_pkg.sv
// Shared sector geometry and drain-FSM encoding for the SD sector packer.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;

  localparam logic [SECTOR_AW-1:0] LAST_ADDR = SECTOR_AW'(SECTOR_BYTES - 1);

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_REQ    = 2'd1,
    D_STREAM = 2'd2,
    D_WAIT   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sd_sector_bank_ram.sv
// Two 512x8 banks in one simple dual-port RAM; one write port and one registered read port.
module sd_sector_bank_ram
  import sd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic                 wr_bank,
  input  logic [SECTOR_AW-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 rd_bank,
  input  logic [SECTOR_AW-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [2*SECTOR_BYTES];

  // NOTE: the array itself is never reset; clearing it would defeat block-RAM inference,
  // and no byte reaches the writer before its bank has been filled.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/sd_sector_packer.sv
// Packs a byte stream into 512-byte sectors across two ping-pong banks and drives
// one block write per full sector to the SD block writer.
module sd_sector_packer
  import sd_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = 32'd0,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inValid,
  output logic        inReady,
  input  logic [7:0]  inData,
  input  logic        flush,
  output logic        flushDone,
  input  logic        wrBusy,
  output logic        startWrite,
  output logic [31:0] writeSectorAddress,
  output logic [7:0]  writeByte,
  input  logic        writeByteSuccess,
  input  logic        writeBlockFinish,
  output logic [31:0] sectorCount
);

  logic                 ready_en;
  logic [1:0]           bank_full;
  logic                 fill_bank;
  logic                 drain_bank;
  logic [SECTOR_AW-1:0] fill_addr;
  logic [SECTOR_AW-1:0] fill_addr_nxt;
  logic [SECTOR_AW-1:0] drain_addr;
  logic                 padding;
  logic                 flush_pend;
  logic                 wr_busy_q;
  drain_state_t         d_state;
  drain_state_t         d_next;

  logic       fill_we;
  logic       fill_last;
  logic [7:0] fill_data;
  logic       flush_take;
  logic       flush_fin;
  logic       byte_take;
  logic       release_bank;
  logic [1:0] fill_set;
  logic [1:0] drain_clr;

  // ---------------- fill side ----------------
  assign inReady       = ready_en & ~bank_full[fill_bank] & ~padding;
  assign fill_we       = padding ? ~bank_full[fill_bank] : (inValid & inReady);
  assign fill_data     = padding ? PAD_BYTE : inData;
  assign fill_last     = fill_we & (fill_addr == LAST_ADDR);
  assign fill_addr_nxt = fill_we ? fill_addr + SECTOR_AW'(1) : fill_addr;

  // Flush completes only once padding is over and both banks have drained.
  assign flush_take = flush & ~flush_pend;
  assign flush_fin  = flush_pend & ~padding & (bank_full == 2'b00) & (d_state == D_IDLE);
  assign flushDone  = flush_fin;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en   <= 1'b0;
      fill_bank  <= 1'b0;
      fill_addr  <= '0;
      padding    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      fill_addr <= fill_addr_nxt;
      if (fill_last) fill_bank <= ~fill_bank;
      // Pad only if a partial sector remains after this cycle's write.
      if (flush_take && (fill_addr_nxt != '0)) padding <= 1'b1;
      else if (fill_last)                      padding <= 1'b0;
      if (flush_take)     flush_pend <= 1'b1;
      else if (flush_fin) flush_pend <= 1'b0;
    end
  end

  // NOTE: every always_comb assigns defaults before any conditional update, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fill_set              = 2'b00;
    drain_clr             = 2'b00;
    fill_set[fill_bank]   = fill_last;
    drain_clr[drain_bank] = release_bank;
  end

  // Fill and drain always target opposite banks, so both updates can land together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bank_full <= 2'b00;
    else       bank_full <= (bank_full | fill_set) & ~drain_clr;
  end

  // ---------------- drain FSM ----------------
  assign byte_take    = (d_state == D_STREAM) & writeByteSuccess;
  assign release_bank = (d_state == D_WAIT) & (writeBlockFinish | (wr_busy_q & ~wrBusy));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_state <= D_IDLE;
    else       d_state <= d_next;
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:   if (bank_full[drain_bank] && !wrBusy)            d_next = D_REQ;
      D_REQ:    if (wrBusy)                                      d_next = D_STREAM;
      D_STREAM: if (byte_take && (drain_addr == LAST_ADDR))      d_next = D_WAIT;
      D_WAIT:   if (release_bank)                                d_next = D_IDLE;
      default:                                                   d_next = D_IDLE;
    endcase
  end

  always_comb begin
    startWrite = (d_state == D_REQ);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_bank         <= 1'b0;
      drain_addr         <= '0;
      wr_busy_q          <= 1'b0;
      writeSectorAddress <= START_SECTOR;
      sectorCount        <= 32'd0;
    end else begin
      wr_busy_q <= wrBusy;
      // 511 + 1 wraps to 0 in SECTOR_AW bits, ready for the next sector.
      if (byte_take) drain_addr <= drain_addr + SECTOR_AW'(1);
      if (release_bank) begin
        drain_bank         <= ~drain_bank;
        writeSectorAddress <= writeSectorAddress + 32'd1;
        sectorCount        <= sectorCount + 32'd1;
      end
    end
  end

  // Read port follows drain_bank/drain_addr every cycle; writeByte lags by one clock.
  sd_sector_bank_ram u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .we      (fill_we),
    .wr_bank (fill_bank),
    .wr_addr (fill_addr),
    .wr_data (fill_data),
    .rd_bank (drain_bank),
    .rd_addr (drain_addr),
    .rd_data (writeByte)
  );

endmodule

// File: tb/tb_sd_sector_packer.sv
// Directed bench for sd_sector_packer with a simple behavioural SD block writer.
module tb_sd_sector_packer;

  localparam logic [31:0] S   = 32'h0000_1000;
  localparam logic [7:0]  PAD = 8'hEE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inData = 8'h00;
  logic        flush = 1'b0;
  logic        flushDone;
  logic        wrBusy = 1'b0;
  logic        startWrite;
  logic [31:0] writeSectorAddress;
  logic [7:0]  writeByte;
  logic        writeByteSuccess = 1'b0;
  logic        writeBlockFinish = 1'b0;
  logic [31:0] sectorCount;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int fd_cnt = 0;
  logic start_q = 1'b0;

  sd_sector_packer #(.START_SECTOR(S), .PAD_BYTE(PAD)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .inValid            (inValid),
    .inReady            (inReady),
    .inData             (inData),
    .flush              (flush),
    .flushDone          (flushDone),
    .wrBusy             (wrBusy),
    .startWrite         (startWrite),
    .writeSectorAddress (writeSectorAddress),
    .writeByte          (writeByte),
    .writeByteSuccess   (writeByteSuccess),
    .writeBlockFinish   (writeBlockFinish),
    .sectorCount        (sectorCount)
  );

  always #5 clk = ~clk;

  // Count write requests (rising edges) and flushDone cycles.
  always @(negedge clk) begin
    if (startWrite && !start_q) start_cnt++;
    start_q = startWrite;
    if (flushDone) fd_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int i, input int mode);
    case (mode)
      0:       return i[7:0];
      1:       return 8'(i + 3 * (i / 512));
      2:       return 8'hA5;
      default: return 8'(i * 7 + mode);
    endcase
  endfunction

  task automatic send(input int base, input int n, input int mode);
    int i = 0;
    int guard = 0;
    while (i < n && guard < n + 20000) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = gen(base + i, mode);
      if (inReady) i++;
      guard++;
    end
    @(negedge clk);
    inValid = 1'b0;
    if (i != n) check("send_timeout", i, n);
  endtask

  task automatic serve_block(input logic [31:0] exp_addr, input int mode, input int base,
                             input int valid_len, input bit do_finish);
    int waited = 0;
    int nbad = 0;
    logic [7:0] e;
    while (!startWrite && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!startWrite) begin
      check("start_timeout", 0, 1);
      return;
    end
    check("sector_addr", writeSectorAddress, exp_addr);
    wrBusy = 1'b1;
    @(negedge clk);
    check("start_drop", startWrite, 0);
    for (int j = 0; j < 512; j++) begin
      repeat (2) @(negedge clk);
      e = (j < valid_len) ? gen(base + j, mode) : PAD;
      if (writeByte !== e) nbad++;
      writeByteSuccess = 1'b1;
      @(negedge clk);
      writeByteSuccess = 1'b0;
    end
    check("byte_mismatches", nbad, 0);
    if (do_finish) begin
      @(negedge clk);
      writeBlockFinish = 1'b1;
      wrBusy = 1'b0;
      @(negedge clk);
      writeBlockFinish = 1'b0;
    end
  endtask

  initial begin
    int s0;
    int f0;
    int waited;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_inready", inReady, 0);
    check("rst_start", startWrite, 0);
    check("rst_flushdone", flushDone, 0);
    check("rst_wbyte", writeByte, 0);
    check("rst_addr", writeSectorAddress, S);
    check("rst_count", sectorCount, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_inready", inReady, 1);

    // One sector 0..255,0..255
    s0 = start_cnt;
    send(0, 512, 0);
    serve_block(S, 0, 0, 512, 1);
    repeat (3) @(negedge clk);
    check("t1_starts", start_cnt - s0, 1);
    check("t1_count", sectorCount, 1);

    // Writer stalled: backpressure after 1024 bytes, then three sectors in order
    s0 = start_cnt;
    wrBusy = 1'b1;
    send(0, 1024, 1);
    repeat (4) @(negedge clk);
    check("stall_inready", inReady, 0);
    check("stall_nostart", start_cnt - s0, 0);
    fork
      send(1024, 512, 1);
      begin
        wrBusy = 1'b0;
        serve_block(S + 1, 1, 0, 512, 1);
        serve_block(S + 2, 1, 512, 512, 1);
        serve_block(S + 3, 1, 1024, 512, 1);
      end
    join
    repeat (3) @(negedge clk);
    check("stall_starts", start_cnt - s0, 3);
    check("stall_count", sectorCount, 4);

    // Fill completes on the same cycle the writer frees the other bank
    s0 = start_cnt;
    send(0, 512, 3);
    serve_block(S + 4, 3, 0, 512, 0);
    send(0, 511, 4);
    @(negedge clk);
    check("sim_inready", inReady, 1);
    inValid = 1'b1;
    inData = gen(511, 4);
    writeBlockFinish = 1'b1;
    wrBusy = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    writeBlockFinish = 1'b0;
    check("sim_count", sectorCount, 5);
    check("sim_inready_after", inReady, 1);
    serve_block(S + 5, 4, 0, 512, 1);
    repeat (50) @(negedge clk);
    check("sim_starts", start_cnt - s0, 2);
    check("sim_count2", sectorCount, 6);

    // Partial sector + flush -> padded sector, single flushDone after drain
    s0 = start_cnt;
    f0 = fd_cnt;
    send(0, 100, 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_early", fd_cnt - f0, 0);
    serve_block(S + 6, 2, 0, 100, 1);
    repeat (4) @(negedge clk);
    check("flush_pulses", fd_cnt - f0, 1);
    check("flush_starts", start_cnt - s0, 1);
    check("flush_count", sectorCount, 7);

    // Flush with nothing buffered -> flushDone the next cycle, no write
    s0 = start_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fd_empty", flushDone, 1);
    @(negedge clk);
    check("fd_empty_off", flushDone, 0);
    repeat (10) @(negedge clk);
    check("fd_empty_nostart", start_cnt - s0, 0);

    // Reset in the middle of streaming
    send(0, 512, 0);
    waited = 0;
    while (!startWrite && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("mid_start_seen", startWrite, 1);
    wrBusy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      repeat (2) @(negedge clk);
      writeByteSuccess = 1'b1;
      @(negedge clk);
      writeByteSuccess = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("mid_wbyte_pre", writeByte, 6);
    rstn = 1'b0;
    #1;
    check("mid_rst_wbyte", writeByte, 0);
    check("mid_rst_start", startWrite, 0);
    check("mid_rst_inready", inReady, 0);
    check("mid_rst_flushdone", flushDone, 0);
    check("mid_rst_addr", writeSectorAddress, S);
    check("mid_rst_count", sectorCount, 0);
    wrBusy = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 512, 5);
    serve_block(S, 5, 0, 512, 1);
    repeat (3) @(negedge clk);
    check("mid_after_count", sectorCount, 1);
    check("mid_after_addr", writeSectorAddress, S + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
